// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants.
// Holds the background animation FSM states, the per-axis payload used by the
// bounce datapath, and the reset centre shared with the background draw stage.
package vga_pkg;

  localparam int unsigned BG_POS_W   = 11;
  localparam int unsigned BG_PHASE_W = 4;
  localparam int unsigned BG_CNT_W   = 8;

  // Reset wave centre; the draw stage uses the same values for its first frame.
  localparam int unsigned BG_X_INIT = 220;
  localparam int unsigned BG_Y_INIT = 240;

  typedef enum logic [1:0] {
    BOUNCE,
    PENDING,
    RIPPLE
  } bg_anim_state_t;

  // One axis of the bounce datapath: direction (1 = moving positive) and position.
  typedef struct packed {
    logic                        dir;
    logic signed [BG_POS_W-1:0]  pos;
  } bg_axis_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between the timing chain and its observers.
// Modports: in (observer side), out (timing generator side).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/bg_anim_ctrl_tick.sv
// frame_tick_gen: vblnk rising-edge detector with a registered one-cycle pulse.
// Ports: clk, rst (sync, active-high), vblnk in, frame_tick out.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic frame_tick
);

  logic vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vblnk_d    <= vblnk;
      frame_tick <= vblnk & ~vblnk_d;
    end
  end

endmodule

// File: rtl/bg_anim_ctrl.sv
// bg_anim_ctrl: per-frame wave centre / phase animation with ripple override.
// Ports: clk, rst (sync, active-high); in (vga_if, only vblnk used);
//   freeze (suppress frame updates); ripple_req/ripple_x/ripple_y request in,
//   ripple_ack pulse out; x_c, y_c (signed centre), phase, ripple_active,
//   frame_tick out. All outputs are registered.
module bg_anim_ctrl
  import vga_pkg::*;
#(
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 1023,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 767,
  parameter int X_INIT        = int'(BG_X_INIT),
  parameter int Y_INIT        = int'(BG_Y_INIT),
  parameter int STEP          = 2,
  parameter int RIPPLE_FRAMES = 60
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_if.in                           in,
  input  logic                        freeze,
  input  logic                        ripple_req,
  input  logic [BG_POS_W-1:0]         ripple_x,
  input  logic [BG_POS_W-1:0]         ripple_y,
  output logic                        ripple_ack,
  output logic signed [BG_POS_W-1:0]  x_c,
  output logic signed [BG_POS_W-1:0]  y_c,
  output logic [BG_PHASE_W-1:0]       phase,
  output logic                        ripple_active,
  output logic                        frame_tick
);

  bg_anim_state_t              state, state_nxt;
  bg_axis_t                    ax, ax_nxt, ay, ay_nxt;
  logic signed [BG_POS_W-1:0]  pend_x, pend_x_nxt, pend_y, pend_y_nxt;
  logic [BG_PHASE_W-1:0]       phase_nxt;
  logic [BG_CNT_W-1:0]         frame_cnt, frame_cnt_nxt;
  logic                        ack_nxt;
  logic                        tick_ok;
  logic                        accept;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (in.vblnk),
    .frame_tick (frame_tick)
  );

  // Clamp an unsigned request coordinate into [lo, hi] in 12-bit signed space.
  function automatic logic signed [BG_POS_W-1:0] clamp_pos(
    input logic [BG_POS_W-1:0] v, input int lo, input int hi);
    logic signed [BG_POS_W:0] s, lo_s, hi_s;
    s    = {1'b0, v};
    lo_s = (BG_POS_W+1)'(lo);
    hi_s = (BG_POS_W+1)'(hi);
    if (s < lo_s)      clamp_pos = BG_POS_W'(lo_s);
    else if (s > hi_s) clamp_pos = BG_POS_W'(hi_s);
    else               clamp_pos = BG_POS_W'(s);
  endfunction

  // One bounce step on an axis; pins to the bound and reverses on overshoot.
  function automatic bg_axis_t bounce(input bg_axis_t a, input int lo, input int hi);
    logic signed [BG_POS_W:0] pos_s, sum, lo_s, hi_s, step_s;
    bg_axis_t r;
    pos_s  = {a.pos[BG_POS_W-1], a.pos};
    lo_s   = (BG_POS_W+1)'(lo);
    hi_s   = (BG_POS_W+1)'(hi);
    step_s = (BG_POS_W+1)'(STEP);
    r      = a;
    if (a.dir) begin
      sum = pos_s + step_s;
      if (sum > hi_s) begin
        r.pos = BG_POS_W'(hi_s);
        r.dir = 1'b0;
      end else begin
        r.pos = BG_POS_W'(sum);
      end
    end else begin
      sum = pos_s - step_s;
      if (sum < lo_s) begin
        r.pos = BG_POS_W'(lo_s);
        r.dir = 1'b1;
      end else begin
        r.pos = BG_POS_W'(sum);
      end
    end
    bounce = r;
  endfunction

  assign tick_ok = frame_tick & ~freeze;
  assign accept  = ripple_req & ((state == BOUNCE) | (state == RIPPLE));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOUNCE;
      ax            <= '{dir: 1'b1, pos: BG_POS_W'(X_INIT)};
      ay            <= '{dir: 1'b1, pos: BG_POS_W'(Y_INIT)};
      pend_x        <= '0;
      pend_y        <= '0;
      phase         <= '0;
      frame_cnt     <= '0;
      ripple_ack    <= 1'b0;
      ripple_active <= 1'b0;
    end else begin
      state         <= state_nxt;
      ax            <= ax_nxt;
      ay            <= ay_nxt;
      pend_x        <= pend_x_nxt;
      pend_y        <= pend_y_nxt;
      phase         <= phase_nxt;
      frame_cnt     <= frame_cnt_nxt;
      ripple_ack    <= ack_nxt;
      ripple_active <= (state_nxt == RIPPLE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    ax_nxt        = ax;
    ay_nxt        = ay;
    pend_x_nxt    = pend_x;
    pend_y_nxt    = pend_y;
    phase_nxt     = phase;
    frame_cnt_nxt = frame_cnt;
    ack_nxt       = 1'b0;

    // Requests are latched the same way from BOUNCE and RIPPLE.
    if (accept) begin
      pend_x_nxt = clamp_pos(ripple_x, X_MIN, X_MAX);
      pend_y_nxt = clamp_pos(ripple_y, Y_MIN, Y_MAX);
      ack_nxt    = 1'b1;
      state_nxt  = PENDING;
    end

    unique case (state)
      BOUNCE: begin
        // Bounce still advances on a coincident request; the new centre waits a tick.
        if (tick_ok) begin
          ax_nxt    = bounce(ax, X_MIN, X_MAX);
          ay_nxt    = bounce(ay, Y_MIN, Y_MAX);
          phase_nxt = phase + BG_PHASE_W'(1);
        end
      end
      PENDING: begin
        if (tick_ok) begin
          ax_nxt.pos    = pend_x;
          ay_nxt.pos    = pend_y;
          phase_nxt     = '0;
          frame_cnt_nxt = BG_CNT_W'(RIPPLE_FRAMES - 1);
          state_nxt     = RIPPLE;
        end
      end
      RIPPLE: begin
        // A coincident request pre-empts the tick: phase and count hold.
        if (tick_ok && !accept) begin
          phase_nxt = phase + BG_PHASE_W'(1);
          if (frame_cnt == '0) state_nxt = BOUNCE;
          else                 frame_cnt_nxt = frame_cnt - BG_CNT_W'(1);
        end
      end
      default: state_nxt = BOUNCE;
    endcase
  end

  assign x_c = ax.pos;
  assign y_c = ay.pos;

endmodule

// File: tb/tb_bg_anim_ctrl.sv
// Scoreboard bench for bg_anim_ctrl: stimulus pushes the hand-computed centre,
// phase and ripple_active expected after each frame tick; monitors pop and
// compare one cycle after every frame_tick and account for every ripple_ack.
module tb_bg_anim_ctrl;

  typedef struct {
    int x;
    int y;
    int ph;
    int act;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               freeze = 1'b0;
  logic               ripple_req = 1'b0;
  logic [10:0]        ripple_x = '0;
  logic [10:0]        ripple_y = '0;
  logic               ripple_ack;
  logic signed [10:0] x_c;
  logic signed [10:0] y_c;
  logic [3:0]         phase;
  logic               ripple_active;
  logic               frame_tick;

  vga_if vif ();

  bg_anim_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in            (vif),
    .freeze        (freeze),
    .ripple_req    (ripple_req),
    .ripple_x      (ripple_x),
    .ripple_y      (ripple_y),
    .ripple_ack    (ripple_ack),
    .x_c           (x_c),
    .y_c           (y_c),
    .phase         (phase),
    .ripple_active (ripple_active),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   exp_acks = 0;
  int   tick_cnt = 0;
  int   frames_issued = 0;
  logic prev_ack = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int x, input int y, input int ph, input int act);
    exp_t e;
    e.x = x; e.y = y; e.ph = ph; e.act = act;
    exp_q.push_back(e);
  endtask

  // One vblnk pulse; optionally raises ripple_req in the cycle frame_tick is high.
  task automatic frame(input bit req_on_tick);
    @(posedge clk); #1 vif.vblnk = 1'b1;
    @(posedge clk); #1 if (req_on_tick) ripple_req = 1'b1;
    @(posedge clk); #1 vif.vblnk = 1'b0;
    if (req_on_tick) ripple_req = 1'b0;
    repeat (4) @(posedge clk);
    frames_issued++;
  endtask

  // Raise a request and require the ack exactly one cycle later.
  task automatic request(input int x, input int y, input bit hold);
    exp_acks++;
    @(posedge clk); #1;
    ripple_x = 11'(x);
    ripple_y = 11'(y);
    ripple_req = 1'b1;
    @(posedge clk); #1;
    chk("ack_latency", int'(ripple_ack), 1);
    if (!hold) ripple_req = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_x_c", int'(x_c), 220);
    chk("rst_y_c", int'(y_c), 240);
    chk("rst_phase", int'(phase), 0);
    chk("rst_active", int'(ripple_active), 0);
    chk("rst_ack", int'(ripple_ack), 0);
    chk("rst_tick", int'(frame_tick), 0);
  endtask

  // Frame monitor: outputs settle one cycle after the frame_tick pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        tick_cnt++;
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("frame_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x_c", int'(x_c), e.x);
          chk("y_c", int'(y_c), e.y);
          chk("phase", int'(phase), e.ph);
          chk("ripple_active", int'(ripple_active), e.act);
        end
      end
    end
  end

  // Ack monitor: every ack must be expected and never last two cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ripple_ack === 1'b1) begin
        chk("ack_expected", int'(exp_acks > 0), 1);
        chk("ack_single", int'(prev_ack), 0);
        if (exp_acks > 0) exp_acks--;
      end
      prev_ack = ripple_ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    vif.hcount = '0;
    vif.vcount = '0;
    vif.hsync  = 1'b0;
    vif.vsync  = 1'b0;
    vif.hblnk  = 1'b0;
    vif.vblnk  = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst = 1'b0;

    // Plain bounce, three frames.
    push(222, 242, 1, 0); frame(0);
    push(224, 244, 2, 0); frame(0);
    push(226, 246, 3, 0); frame(0);

    // Ripple to (500,400), held for 60 ticks, then bounce resumes.
    request(500, 400, 1'b0);
    push(500, 400, 0, 1); frame(0);
    for (int k = 1; k <= 60; k++) begin
      push(500, 400, k % 16, (k < 60) ? 1 : 0);
      frame(0);
    end
    push(502, 402, 13, 0); frame(0);

    // Request held through PENDING; clamped to (1023,767); re-acked once in RIPPLE.
    request(2000, 1500, 1'b1);
    repeat (5) @(posedge clk);
    exp_acks++;
    push(1023, 767, 0, 1); frame(0);
    #1 ripple_req = 1'b0;
    push(1023, 767, 0, 1); frame(0);

    // Request coincident with a tick while in RIPPLE: acceptance wins.
    ripple_x = 11'(100);
    ripple_y = 11'(50);
    exp_acks++;
    push(1023, 767, 0, 0); frame(1);
    push(100, 50, 0, 1); frame(0);

    // Freeze holds a PENDING request across five ticks.
    request(300, 200, 1'b0);
    freeze = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(100, 50, 0, 0);
      frame(0);
    end
    freeze = 1'b0;
    push(300, 200, 0, 1); frame(0);
    push(300, 200, 1, 1); frame(0);

    // Reset mid-ripple.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 chk_reset();
    rst = 1'b0;
    push(222, 242, 1, 0); frame(0);

    // Upper bounds: 1022+2 pins to 1023 and reverses, then 1021.
    request(1022, 766, 1'b0);
    push(1022, 766, 0, 1); frame(0);
    for (int k = 1; k <= 60; k++) begin
      push(1022, 766, k % 16, (k < 60) ? 1 : 0);
      frame(0);
    end
    push(1023, 767, 13, 0); frame(0);
    push(1021, 765, 14, 0); frame(0);

    repeat (4) @(posedge clk);
    chk("tick_count", tick_cnt, frames_issued);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("acks_outstanding", exp_acks, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bg_anim_ctrl.md
# bg_anim_ctrl

Per-frame animation controller for the background wave renderer. It owns the wave centre (x_c, y_c) and a 4-bit wave phase, and updates them once per frame during vertical blanking, so values stay stable across active video. It sits beside the timing chain, watches VGA timing through vga_if, and feeds its outputs to the background draw stage. It also arbitrates a "ripple" request from game logic, such as a tile click, which re-centres the wave for a fixed number of frames.

## Interface
Parameters:
- X_MIN, 0: left bound of the centre.
- X_MAX, 1023: right bound of the centre.
- Y_MIN, 0: top bound of the centre.
- Y_MAX, 767: bottom bound of the centre.
- X_INIT, 220: reset x_c.
- Y_INIT, 240: reset y_c.
- STEP, 2: pixels moved per frame in bounce mode; 1..15.
- RIPPLE_FRAMES, 60: frames a ripple lasts; 1..255.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- in  vga_if.in  -  timing monitor. Only vblnk is used; all other fields are ignored.
- freeze  in  1  level; suppresses all per-frame updates.
- ripple_req  in  1  ripple request, held high until ack.
- ripple_x  in  11  requested centre x, unsigned, sampled with the request.
- ripple_y  in  11  requested centre y, unsigned, sampled with the request.
- ripple_ack  out  1  one-cycle pulse acknowledging acceptance.
- x_c  out  11 signed  wave centre x.
- y_c  out  11 signed  wave centre y.
- phase  out  4  wave phase, wraps mod 16.
- ripple_active  out  1  high while state is RIPPLE.
- frame_tick  out  1  one-cycle pulse on each vblnk rising edge.

## Operation
- Edge detect: vblnk_d <= in.vblnk. frame_tick <= in.vblnk & ~vblnk_d.
- FSM states: BOUNCE, PENDING, RIPPLE.
- Request acceptance:
  - Allowed when the state is BOUNCE or RIPPLE and ripple_req=1.
  - On acceptance, latch pend_x = clamp(ripple_x, X_MIN, X_MAX) and pend_y = clamp(ripple_y, Y_MIN, Y_MAX).
  - Pulse ripple_ack and move to PENDING.
  - In PENDING, requests are ignored and no ack is given. The requester keeps req high until ack and drops it in the cycle after ack.
- Per-frame update happens on a frame_tick with freeze=0. With freeze=1, the tick is discarded, nothing changes, and a PENDING request stays pending.
- BOUNCE, x axis (y axis is identical, using dir_y, Y_MIN, Y_MAX):
  - Moving positive (dir_x=+): if x_c+STEP > X_MAX then x_c <= X_MAX and dir_x <= −; otherwise x_c += STEP.
  - Moving negative: if x_c−STEP < X_MIN then x_c <= X_MIN and dir_x <= +; otherwise x_c −= STEP.
  - Bound comparisons are done in 12-bit signed arithmetic.
  - phase += 1.
- PENDING on tick: x_c <= pend_x, y_c <= pend_y, phase <= 0, frame_cnt <= RIPPLE_FRAMES−1, go to RIPPLE.
- RIPPLE on tick:
  - phase += 1.
  - If frame_cnt==0, go to BOUNCE, keeping position and directions.
  - Otherwise frame_cnt −= 1.
- Simultaneous request and tick:
  - In BOUNCE: the bounce update is applied and the request is accepted in the same cycle. The new centre loads on the next tick.
  - In RIPPLE: acceptance wins. State goes to PENDING, and phase and frame_cnt are unchanged for that tick.
- Reset values:
  - x_c=X_INIT, y_c=Y_INIT; dir_x=+, dir_y=+.
  - phase=0, frame_cnt=0, state=BOUNCE.
  - ripple_ack=0, frame_tick=0, ripple_active=0, vblnk_d=0.
- Reset mid-ripple or while PENDING drops the request; no ack is pending afterwards.

## Timing
- vblnk rises at cycle t → frame_tick=1 at t+1 → x_c, y_c, phase and ripple_active are updated at t+2.
- Outputs are registered and change only at t+2 of a vblnk edge, which falls inside blanking.
- ripple_req sampled high at cycle t while accepting → ripple_ack=1 and state=PENDING at t+1. Ack is never high for two consecutive cycles.
- Request-to-centre latency is one frame tick after acceptance, plus 1 cycle.
- A ripple lasts exactly RIPPLE_FRAMES ticks after load (ticks with freeze=0).

## Structure
- vga_pkg gains:
  - typedef enum logic [1:0] bg_anim_state_t {BOUNCE, PENDING, RIPPLE}.
  - BG_X_INIT and BG_Y_INIT constants, shared with the draw stage.
- Sub-module frame_tick_gen: the vblnk rising-edge detector with registered pulse output. It is reusable by other per-frame blocks.
- Top level contains the FSM, the bounce datapath, the request latch and the ripple counter.

## Test plan
- Reset then 3 vblnk edges, no req, STEP=2 → x_c 220→222→224→226, y_c 240→…→246, phase=3; frame_tick pulses exactly 3 times.
- Set x_c to 1022, dir_x=+ → after the next tick x_c=1023 and dir_x=−; after the following tick x_c=1021.
- ripple_req with (500,400) mid-frame → ack 1 cycle later. At the next tick+1: x_c=500, y_c=400, phase=0, ripple_active=1. After 60 further ticks: ripple_active=0, centre held at (500,400) and bounce resumes.
- req high continuously (no drop) while PENDING → no second ack until a tick loads RIPPLE, then a second ack. ripple_x=2000 → clamped to x_c=1023.
- req coincident with frame_tick in RIPPLE → ack, state PENDING, phase unchanged; the next tick reloads the new centre.
- freeze=1 across 5 ticks in PENDING → all outputs stable. Release freeze → load on the next tick. rst asserted mid-RIPPLE → all reset values on the following cycle.
